// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_port_arbiter                                                         |
// | Shares one single-port SRAM between fetch and data ports, data first,    |
// | and routes fixed-latency read responses back to the issuing port.        |
// | Optional fetch fairness guard: define MEMARB_FAIRNESS_EN.                |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mem_port_arbiter #(
    parameter int AW       = 14,
    parameter int DW       = 32,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          im_req,
    input  logic [AW-1:0] im_addr,
    input  logic          im_kill,
    output logic          im_gnt,
    output logic          im_rvalid,
    output logic [DW-1:0] im_rdata,
    input  logic          dm_req,
    input  logic          dm_web,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_bweb,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdata,
    output logic          sram_ceb,
    output logic          sram_web,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_bweb,
    output logic [DW-1:0] sram_din,
    input  logic [DW-1:0] sram_dout,
    output logic          mem_stall
);

    logic              w_force_im;
    logic              w_push_vld;
    logic              w_push_src;
    logic [RD_LAT-1:0] w_vld_nxt;
    logic [RD_LAT-1:0] w_src_nxt;
    logic [RD_LAT-1:0] r_vld;
    logic [RD_LAT-1:0] r_src;
    logic              r_web;
    logic [AW-1:0]     r_addr;
    logic [DW-1:0]     r_bweb;
    logic [DW-1:0]     r_din;

`ifdef MEMARB_FAIRNESS_EN
    logic [1:0] r_wait;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait <= 2'd0;
        end else if (!im_req || im_gnt) begin
            r_wait <= 2'd0;
        end else if (r_wait != 2'd3) begin
            r_wait <= r_wait + 2'd1;
        end
    end

    assign w_force_im = im_req && (r_wait == 2'(MAX_WAIT));
`else
    assign w_force_im = 1'b0;
`endif

    assign dm_gnt    = !rst && dm_req && !w_force_im;
    assign im_gnt    = !rst && im_req && !dm_gnt;
    assign mem_stall = !rst && ((im_req && !im_gnt) || (dm_req && !dm_gnt));

    // Idle cycles replay the last command fields so the macro pins stay quiet.
    always_comb begin
        sram_ceb  = 1'b1;
        sram_web  = r_web;
        sram_addr = r_addr;
        sram_bweb = r_bweb;
        sram_din  = r_din;
        if (dm_gnt) begin
            sram_ceb  = 1'b0;
            sram_web  = dm_web;
            sram_addr = dm_addr;
            sram_bweb = dm_bweb;
            sram_din  = dm_wdata;
        end else if (im_gnt) begin
            sram_ceb  = 1'b0;
            sram_web  = 1'b1;
            sram_addr = im_addr;
            sram_bweb = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_web  <= 1'b1;
            r_addr <= '0;
            r_bweb <= '1;
            r_din  <= '0;
        end else if (!sram_ceb) begin
            r_web  <= sram_web;
            r_addr <= sram_addr;
            r_bweb <= sram_bweb;
            r_din  <= sram_din;
        end
    end

    assign w_push_vld = im_gnt || (dm_gnt && dm_web);
    assign w_push_src = im_gnt;

    // The last stage is being presented this cycle, so kill only affects younger entries.
    always_comb begin
        w_vld_nxt    = '0;
        w_src_nxt    = '0;
        w_vld_nxt[0] = w_push_vld;
        w_src_nxt[0] = w_push_src;
        for (int i = 1; i < RD_LAT; i++) begin
            w_vld_nxt[i] = r_vld[i-1] && !(im_kill && r_src[i-1]);
            w_src_nxt[i] = r_src[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            r_src <= '0;
        end else begin
            r_vld <= w_vld_nxt;
            r_src <= w_src_nxt;
        end
    end

    assign im_rvalid = !rst && r_vld[RD_LAT-1] &&  r_src[RD_LAT-1];
    assign dm_rvalid = !rst && r_vld[RD_LAT-1] && !r_src[RD_LAT-1];
    assign im_rdata  = sram_dout;
    assign dm_rdata  = sram_dout;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_port_arbiter                                                      |
// | Scoreboard bench: behavioural SRAM, grant model, queued read responses.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_mem_port_arbiter;

    localparam int AW       = 14;
    localparam int DW       = 32;
    localparam int RD_LAT   = 2;
    localparam int MAX_WAIT = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          im_req, im_kill, im_gnt, im_rvalid;
    logic [AW-1:0] im_addr;
    logic [DW-1:0] im_rdata;
    logic          dm_req, dm_web, dm_gnt, dm_rvalid;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_bweb, dm_wdata, dm_rdata;
    logic          sram_ceb, sram_web, mem_stall;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_bweb, sram_din, sram_dout;

    mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)) u_dut (
        .clk(clk), .rst(rst),
        .im_req(im_req), .im_addr(im_addr), .im_kill(im_kill), .im_gnt(im_gnt),
        .im_rvalid(im_rvalid), .im_rdata(im_rdata),
        .dm_req(dm_req), .dm_web(dm_web), .dm_addr(dm_addr), .dm_bweb(dm_bweb),
        .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .sram_ceb(sram_ceb), .sram_web(sram_web), .sram_addr(sram_addr),
        .sram_bweb(sram_bweb), .sram_din(sram_din), .sram_dout(sram_dout),
        .mem_stall(mem_stall)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return 32'h5A000000 ^ {a, 2'b01, a, 2'b10};
    endfunction

    // Behavioural SRAM driven only by the DUT's macro pins.
    logic [DW-1:0] mem     [2**AW];
    bit            mem_ok  [2**AW];
    logic [DW-1:0] rd_pipe [RD_LAT];

    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        return mem_ok[a] ? mem[a] : init_val(a);
    endfunction

    always @(posedge clk) begin
        if (!sram_ceb && !sram_web) begin
            mem[sram_addr]    <= (mem_rd(sram_addr) & sram_bweb) | (sram_din & ~sram_bweb);
            mem_ok[sram_addr] <= 1'b1;
        end
        if (!sram_ceb && sram_web) rd_pipe[0] <= mem_rd(sram_addr);
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign sram_dout = rd_pipe[RD_LAT-1];

    // Reference memory, updated from the bench's own grant prediction.
    logic [DW-1:0] ref_mem [2**AW];
    bit            ref_ok  [2**AW];

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_ok[a] ? ref_mem[a] : init_val(a);
    endfunction

    typedef struct {
        bit            is_im;
        logic [DW-1:0] data;
        int            due;
    } rsp_t;

    rsp_t q[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_err  = 0;
    bit   prev_r = 1'b1;
`ifdef MEMARB_FAIRNESS_EN
    logic [1:0] m_wait = 2'd0;
`endif

    task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic cyc_step(input logic r, input logic ir, input logic [AW-1:0] ia, input logic ik,
                            input logic dr, input logic dw, input logic [AW-1:0] da,
                            input logic [DW-1:0] db, input logic [DW-1:0] dd);
        logic e_im, e_dm, e_iv, e_dv, force_im;
        rsp_t e;
        rst = r; im_req = ir; im_addr = ia; im_kill = ik;
        dm_req = dr; dm_web = dw; dm_addr = da; dm_bweb = db; dm_wdata = dd;
        @(negedge clk);
        e_iv = 1'b0;
        e_dv = 1'b0;
        if (q.size() != 0 && q[0].due == cyc) begin
            e    = q.pop_front();
            e_iv = !r && e.is_im;
            e_dv = !r && !e.is_im;
        end
        check("im_rvalid", 32'(im_rvalid), 32'(e_iv));
        check("dm_rvalid", 32'(dm_rvalid), 32'(e_dv));
        if (e_iv) check("im_rdata", im_rdata, e.data);
        if (e_dv) check("dm_rdata", dm_rdata, e.data);

        force_im = 1'b0;
`ifdef MEMARB_FAIRNESS_EN
        force_im = ir && (m_wait == 2'(MAX_WAIT));
`endif
        e_dm = !r && dr && !force_im;
        e_im = !r && ir && !e_dm;
        check("dm_gnt", 32'(dm_gnt), 32'(e_dm));
        check("im_gnt", 32'(im_gnt), 32'(e_im));
        check("mem_stall", 32'(mem_stall), 32'(!r && ((ir && !e_im) || (dr && !e_dm))));
        check("sram_ceb", 32'(sram_ceb), 32'(!(e_im || e_dm)));
        if (r && prev_r) begin
            check("rst_sram_addr", 32'(sram_addr), 32'd0);
            check("rst_sram_bweb", sram_bweb, '1);
            check("rst_sram_web", 32'(sram_web), 32'd1);
        end
        if (e_dm || e_im) begin
            check("sram_addr", 32'(sram_addr), 32'(e_dm ? da : ia));
            check("sram_web", 32'(sram_web), 32'(e_dm ? dw : 1'b1));
        end
        if (e_dm && !dw) begin
            check("sram_bweb", sram_bweb, db);
            check("sram_din", sram_din, dd);
        end

        if (r) begin
            q.delete();
        end else begin
            if (ik) begin
                rsp_t keep[$];
                foreach (q[i]) if (!q[i].is_im) keep.push_back(q[i]);
                q = keep;
            end
            if (e_im) q.push_back('{1'b1, ref_rd(ia), cyc + RD_LAT});
            if (e_dm && dw) q.push_back('{1'b0, ref_rd(da), cyc + RD_LAT});
            if (e_dm && !dw) begin
                ref_mem[da] = (ref_rd(da) & db) | (dd & ~db);
                ref_ok[da]  = 1'b1;
            end
        end
`ifdef MEMARB_FAIRNESS_EN
        if (r || !ir || e_im) m_wait = 2'd0;
        else if (m_wait != 2'd3) m_wait = m_wait + 2'd1;
`endif
        prev_r = r;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc_step(0, 0, '0, 0, 0, 1, '0, '1, '0);
    endtask

    initial begin
        rst = 1'b1; im_req = 1'b0; im_addr = '0; im_kill = 1'b0;
        dm_req = 1'b0; dm_web = 1'b1; dm_addr = '0; dm_bweb = '1; dm_wdata = '0;
        @(posedge clk);
        #1;

        // Reset held with both ports requesting, then data wins on release.
        repeat (2) cyc_step(1, 1, 14'h0010, 0, 1, 1, 14'h0100, '1, '0);
        cyc_step(0, 1, 14'h0010, 0, 1, 1, 14'h0100, '1, '0);
        idle(3);

        for (int i = 0; i < 4; i++) cyc_step(0, 1, AW'(16 + i), 0, 0, 1, '0, '1, '0);
        idle(3);

        cyc_step(0, 1, 14'h0020, 0, 1, 1, 14'h0200, '1, '0);
        cyc_step(0, 1, 14'h0020, 0, 0, 1, '0, '1, '0);
        idle(3);

        cyc_step(0, 0, '0, 0, 1, 0, 14'h0005, 32'h0000FFFF, 32'hDEADBEEF);
        cyc_step(0, 0, '0, 0, 1, 1, 14'h0005, '1, '0);
        idle(3);

        // Kill drops the older fetch but keeps the redirect-target fetch.
        cyc_step(0, 1, 14'h0030, 0, 0, 1, '0, '1, '0);
        cyc_step(0, 1, 14'h0031, 1, 0, 1, '0, '1, '0);
        idle(4);

        // Kill must leave an in-flight data read intact.
        cyc_step(0, 0, '0, 0, 1, 1, 14'h0050, '1, '0);
        cyc_step(0, 1, 14'h0032, 1, 0, 1, '0, '1, '0);
        idle(4);

        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) cyc_step(0, 0, '0, 0, 1, 1, AW'(64 + i), '1, '0);
            else            cyc_step(0, 1, AW'(64 + i), 0, 0, 1, '0, '1, '0);
        end
        idle(3);

        repeat (8) cyc_step(0, 1, 14'h0060, 0, 1, 1, 14'h0070, '1, '0);
        cyc_step(0, 1, 14'h0060, 0, 0, 1, '0, '1, '0);
        idle(3);

        // Reset with responses still in flight.
        cyc_step(0, 1, 14'h0080, 0, 0, 1, '0, '1, '0);
        cyc_step(0, 0, '0, 0, 1, 1, 14'h0081, '1, '0);
        cyc_step(1, 1, 14'h0082, 0, 1, 1, 14'h0083, '1, '0);
        idle(4);

        for (int n = 0; n < 60; n++) begin
            logic          ir, ik, dr, dw;
            logic [AW-1:0] ia, da;
            logic [DW-1:0] db, dd;
            ir = 1'($urandom_range(0, 1));
            ik = ($urandom_range(0, 5) == 0);
            dr = 1'($urandom_range(0, 1));
            dw = 1'($urandom_range(0, 1));
            ia = AW'($urandom_range(0, 7));
            da = AW'($urandom_range(0, 7));
            db = $urandom();
            dd = $urandom();
            cyc_step(0, ir, ia, ik, dr, dw, da, db, dd);
        end
        idle(RD_LAT + 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
